// File: rtl/lutram_fifo_ctrl.sv
// lutram_fifo_ctrl: pointer and flow-control stage that turns an external dual-port LUT RAM
// (one write port, one asynchronous read port) into a synchronous FIFO of 2**addr_width entries.
//
// Optional feature macro: LUTRAM_FIFO_CLEAR_EN
//   Defined:   after reset the block walks every RAM address writing zero (CLEAR state)
//              before accepting traffic (RUN state).
//   Undefined: no clear FSM; the block is in RUN straight out of reset.
//
// Ports:
//   CLK        clock, all state updates on the rising edge
//   RST_N      asynchronous active-low reset
//   ENQ        push request, honoured only when NOT_FULL
//   ENQ_DATA   entry to push
//   NOT_FULL   FIFO can accept an entry this cycle
//   DEQ        pop request, honoured only when NOT_EMPTY
//   FIRST      head entry, valid while NOT_EMPTY
//   NOT_EMPTY  FIFO holds at least one entry
//   COUNT      current occupancy, 0..2**addr_width
//   RAM_WADDR  RAM write address
//   RAM_WDATA  RAM write data
//   RAM_WE     RAM write enable
//   RAM_RADDR  RAM read address
//   RAM_RDATA  RAM asynchronous read data
module lutram_fifo_ctrl #(
    parameter int unsigned addr_width = 4,
    parameter int unsigned data_width = 8
) (
    input  logic                  CLK,
    input  logic                  RST_N,
    input  logic                  ENQ,
    input  logic [data_width-1:0] ENQ_DATA,
    output logic                  NOT_FULL,
    input  logic                  DEQ,
    output logic [data_width-1:0] FIRST,
    output logic                  NOT_EMPTY,
    output logic [addr_width:0]   COUNT,
    output logic [addr_width-1:0] RAM_WADDR,
    output logic [data_width-1:0] RAM_WDATA,
    output logic                  RAM_WE,
    output logic [addr_width-1:0] RAM_RADDR,
    input  logic [data_width-1:0] RAM_RDATA
);

    // Occupancy value meaning "full": 2**addr_width.
    localparam logic [addr_width:0] FullCount = {1'b1, {addr_width{1'b0}}};

    logic [addr_width-1:0] wr_ptr_q, wr_ptr_d;
    logic [addr_width-1:0] rd_ptr_q, rd_ptr_d;
    logic [addr_width:0]   count_q, count_d;

    logic run;
    logic not_full, not_empty;
    logic enq_ok, deq_ok;

`ifdef LUTRAM_FIFO_CLEAR_EN
    typedef enum logic [0:0] {StClear, StRun} state_e;

    state_e                state_q, state_d;
    logic [addr_width-1:0] clr_addr_q, clr_addr_d;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q    <= StClear;
            clr_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            clr_addr_q <= clr_addr_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        clr_addr_d = clr_addr_q;
        unique case (state_q)
            StClear: begin
                clr_addr_d = clr_addr_q + 1'b1;
                // Last address written this cycle: traffic may start next cycle.
                if (clr_addr_q == {addr_width{1'b1}}) begin
                    state_d = StRun;
                end
            end
            StRun: state_d = StRun;
        endcase
    end

    assign run = (state_q == StRun);
`else
    assign run = 1'b1;
`endif

    // Flags decode only registered state, so ENQ/DEQ never reach them combinationally.
    assign not_full  = run && (count_q != FullCount);
    assign not_empty = run && (count_q != '0);

    assign enq_ok = ENQ && not_full;
    assign deq_ok = DEQ && not_empty;

    assign NOT_FULL  = not_full;
    assign NOT_EMPTY = not_empty;
    assign COUNT     = count_q;
    assign RAM_RADDR = rd_ptr_q;
    assign FIRST     = RAM_RDATA;

    // RST_N gates the write enable directly: the flags reset asynchronously, but ENQ could
    // otherwise still pulse a write while reset is held.
    always_comb begin
        RAM_WE    = enq_ok && RST_N;
        RAM_WADDR = wr_ptr_q;
        RAM_WDATA = ENQ_DATA;
`ifdef LUTRAM_FIFO_CLEAR_EN
        if (state_q == StClear) begin
            RAM_WE    = RST_N;
            RAM_WADDR = clr_addr_q;
            RAM_WDATA = '0;
        end
`endif
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (enq_ok) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (deq_ok) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        if (enq_ok && !deq_ok) begin
            count_d = count_q + 1'b1;
        end else if (deq_ok && !enq_ok) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule
